// File: rtl/seg7_pkg.sv
// Shared segment codes and sizing helpers for the 7-segment scan driver.
package seg7_pkg;

  // Segment codes in {a,b,c,d,e,f,g} order, active-high.
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to abcdefg decoder; codes 10..15 decode dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned value updates,
// per-slot anti-ghosting gap and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned BLANK_CYCLES  = 500,
  parameter int unsigned AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned IdxW  = idx_width(NUM_DIGITS);
  localparam int unsigned SlotW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] AnOff = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shown_q, shown_d;
  logic [SlotW-1:0]        slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]         dig_idx_q, dig_idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    slot_last, dig_last, frame_end;
  logic [3:0]              cur_digit;
  logic                    lz_blank, higher_zero;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    in_gap;

  assign slot_last = (slot_cnt_q == SlotW'(REFRESH_DIV - 1));
  assign dig_last  = (dig_idx_q == IdxW'(NUM_DIGITS - 1));
  assign frame_end = slot_last && dig_last;

  // A load on the boundary cycle reaches shown directly through pending_d.
  always_comb begin
    pending_d  = load ? bcd_in : pending_q;
    shown_d    = frame_end ? pending_d : shown_q;
    slot_cnt_d = slot_last ? '0 : slot_cnt_q + SlotW'(1);
    dig_idx_d  = dig_idx_q;
    if (slot_last) begin
      dig_idx_d = dig_last ? '0 : dig_idx_q + IdxW'(1);
    end
  end

  // Digit mux plus leading-zero test, walking from the most significant digit down.
  always_comb begin
    cur_digit   = 4'd0;
    lz_blank    = 1'b0;
    higher_zero = 1'b1;
    onehot      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero && (shown_q[4*k +: 4] == 4'd0);
      onehot[k]   = (dig_idx_q == IdxW'(k));
      if (dig_idx_q == IdxW'(k)) begin
        cur_digit = shown_q[4*k +: 4];
        lz_blank  = blank_lz && (k != 0) && higher_zero;
      end
    end
  end

  seg7_decode u_decode (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    in_gap = (32'(slot_cnt_q) < BLANK_CYCLES);
    fs_d   = (slot_cnt_q == '0) && (dig_idx_q == '0);
    if (in_gap) begin
      an_d  = AnOff;
      seg_d = SEG_OFF;
    end else begin
      an_d  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg_d = lz_blank ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      shown_q    <= '0;
      slot_cnt_q <= '0;
      dig_idx_q  <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AnOff;
      fs_q       <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      shown_q    <= shown_d;
      slot_cnt_q <= slot_cnt_d;
      dig_idx_q  <= dig_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-level reference model queues the expected
// outputs, a monitor on the falling edge compares them against the DUT.
module tb_seg7_scan_driver;

  localparam int unsigned N     = 2;
  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = N * DIV;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [7:0]   bcd_in;
  logic         blank_lz;
  logic [6:0]   seg;
  logic [1:0]   an;
  logic         frame_start;

  int unsigned  compared   = 0;
  int unsigned  mismatched = 0;

  logic [9:0]   exp_q[$];
  int unsigned  t;
  logic [7:0]   m_pend;
  logic [7:0]   m_shown;

  seg7_scan_driver #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (DIV),
    .BLANK_CYCLES  (BLANK),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .bcd_in      (bcd_in),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_decode(input int unsigned v);
    case (v)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: t counts cycles since reset; slot and digit follow arithmetically.
  initial begin
    t       = 0;
    m_pend  = 8'h00;
    m_shown = 8'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.push_back({7'b0000000, 2'b11, 1'b0});
        t       = 0;
        m_pend  = 8'h00;
        m_shown = 8'h00;
      end else begin
        int unsigned slot, d, digit, above;
        logic [6:0]  e_seg;
        logic [1:0]  e_an;
        logic        e_fs;
        slot  = t % DIV;
        d     = (t / DIV) % N;
        digit = (int'(m_shown) >> (4 * d)) & 15;
        above = int'(m_shown) >> (4 * d);
        e_fs  = (slot == 0) && (d == 0);
        if (slot < BLANK) begin
          e_an  = 2'b11;
          e_seg = 7'b0000000;
        end else begin
          e_an  = (d == 0) ? 2'b10 : 2'b01;
          e_seg = (blank_lz && d > 0 && above == 0) ? 7'b0000000 : ref_decode(digit);
        end
        exp_q.push_back({e_seg, e_an, e_fs});
        if (load) m_pend = bcd_in;
        if (slot == DIV - 1 && d == N - 1) m_shown = m_pend;
        t++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        compared++;
        if ({seg, an, frame_start} !== e) begin
          mismatched++;
          $display("FAIL outputs @%0t: got seg=%b an=%b fs=%b, expected seg=%b an=%b fs=%b",
                   $time, seg, an, frame_start, e[9:3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
    bcd_in = 8'($urandom);
  endtask

  // Aligns to the negedge before the posedge at which the model's frame position is p.
  task automatic wait_pos(input int unsigned p);
    int unsigned n;
    n = 0;
    while ((t % FRAME) != p && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((t % FRAME) != p) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pos: got position %0d, required %0d", t % FRAME, p);
    end
  endtask

  function automatic logic [7:0] rand_bcd();
    logic [3:0] d0, d1;
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    d0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
    d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
    return {d1, d0};
  endfunction

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = 8'h00;
    blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycles(20);

    // Mid-frame load, visible only from the next frame.
    wait_pos(5);
    pulse_load(8'h42);
    cycles(40);

    blank_lz = 1'b1;
    pulse_load(8'h07);
    cycles(34);
    pulse_load(8'h00);
    cycles(34);
    pulse_load(8'h70);
    cycles(34);
    blank_lz = 1'b0;

    // Two loads in one frame, then a third on the boundary cycle itself.
    wait_pos(3);
    pulse_load(8'h11);
    cycles(3);
    pulse_load(8'h99);
    wait_pos(FRAME - 1);
    pulse_load(8'h55);
    cycles(34);

    pulse_load(8'hA3);
    cycles(34);

    // Reset during the digit-1 active portion.
    wait_pos(DIV + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(34);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) begin
        load   = 1'b1;
        bcd_in = rand_bcd();
      end else begin
        load   = 1'b0;
        bcd_in = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    rst  = 1'b0;
    load = 1'b0;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Sits directly downstream of the binary-to-BCD converter; consumes its packed BCD digits.
- Scans one digit per refresh slot, decodes BCD to abcdefg segments, optionally blanks leading zeros, and inserts an anti-ghosting blank gap at each digit switch.
- Updates the displayed value only at frame boundaries, so a display is never torn.

Parameters:
- NUM_DIGITS, 2, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 0 disables the gap.
- AN_ACTIVE_LOW, 1, 1 = anode enables are active-low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures bcd_in.
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit 0 (ones) in [3:0], digit k in [4k+3:4k].
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high, registered.
- an  out  NUM_DIGITS  anode enables; bit k drives digit k; registered.
- frame_start  out  1  one-cycle pulse when the digit-0 slot begins.

Behaviour:
- One clock; all state updates on rising clk; rst is synchronous, active-high.
- State registers:
  - pending: captures bcd_in on any cycle with load=1.
  - shown: the value being displayed.
  - slot_cnt: 0..REFRESH_DIV-1.
  - dig_idx: 0..NUM_DIGITS-1.
- Reset values:
  - pending = 0, shown = 0, slot_cnt = 0, dig_idx = 0.
  - seg = 7'b0000000, an = all inactive, frame_start = 0.
  - rst asserted mid-frame aborts the scan immediately; the next scan starts at the digit-0 slot with a full blank gap.
- Slot counter:
  - slot_cnt increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and dig_idx advances; dig_idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary (the cycle where dig_idx goes to 0 and slot_cnt goes to 0):
  - shown <= pending.
  - If load=1 in that same cycle, bcd_in bypasses pending and goes straight into shown.
  - Multiple loads within one frame: the last one wins.
- Output latency: seg, an and frame_start are registered and reflect (slot_cnt, dig_idx, shown) with exactly 1 cycle latency.
- Blank gap: while slot_cnt < BLANK_CYCLES, an = all inactive and seg = 0.
- Active portion of a slot:
  - Only bit dig_idx of an is active.
  - seg = decode(shown digit dig_idx).
- Decode map (abcdefg):
  - 0 → 1111110, 1 → 0110000, 2 → 1101101, 3 → 1111001, 4 → 0110011
  - 5 → 1011011, 6 → 1011111, 7 → 1110000, 8 → 1111111, 9 → 1111011
  - codes 10..15 → 0000000 (illegal BCD is shown dark, never as garbage).
- Leading-zero blanking:
  - Applies when blank_lz=1.
  - Digit k > 0 is blanked (seg = 0, anode still active) if it and every higher digit are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - blank_lz is sampled live each cycle and is not latched.
- frame_start: asserted in the output cycle corresponding to slot_cnt = 0, dig_idx = 0, including the first slot after reset.
- NUM_DIGITS = 1: dig_idx is constant 0; every slot is a frame boundary.

Decomposition:
- Shared package seg7_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_OFF (abcdefg order);
  - localparam function for the dig_idx width: clog2(NUM_DIGITS), minimum 1.
- One natural sub-module, seg7_decode: combinational 4-bit BCD to 7-bit abcdefg, with illegal codes mapped to SEG_OFF. It is instantiated once, after the digit mux.

Test Plan:
All scenarios use NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2, AN_ACTIVE_LOW=1.
- Reset/idle: hold rst 3 cycles, release → an=2'b11 and seg=0 while held; frame_start pulses 1 cycle after release; cycles 3..8 show an=2'b10, seg=1111110.
- Basic scan: load bcd_in=8'h42 mid-frame → first change occurs only at the next frame_start. Then digit0 slot gives an=2'b10, seg=1101101; digit1 slot gives an=2'b01, seg=0110011. Each slot has 2 cycles with an=2'b11 and seg=0 at its start; frame period is 16 cycles.
- Leading zeros: blank_lz=1, load 8'h07 → digit1 slot has an=2'b01, seg=0000000; digit0 slot shows 1110000. Load 8'h00 → digit0 shows 1111110 and digit1 is dark. Load 8'h70 → both digits lit (1110000, 1111110).
- Tear-free load: load 8'h11 then 8'h99 in the same frame, and 8'h55 exactly on the frame-boundary cycle → next frame shows 55 on both digits (1011011); 11 and 99 are never displayed.
- Illegal BCD: load 8'hA3 → digit0 shows 1111001, digit1 shows 0000000.
- Reset mid-slot: assert rst during the digit1 active portion → next cycle an=2'b11, seg=0, shown=00. After release, scanning restarts at digit0 with frame_start; the displayed value is 0 until a new load.
